regs_arbiter: RTL and testbench
===============================

REGS_ARBITER -- requirements
Module: regs_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 The block SHALL have parameter MAX_HOLD, default 4, max consecutive locked grants to one requester (range 1..15).
REQ-004 The block SHALL have these ports:
  i_CLK  input  1  single clock; all state updates on rising edge
  i_RSTn  input  1  reset, synchronous, active-low
  i_reqN_valid  input  1  requester N (N=0,1) has a request
  i_reqN_lock  input  1  requester N asks to keep ownership after this grant
  i_reqN_we  input  1  request includes a write
  i_reqN_ra0, i_reqN_ra1  input  ADDR_WIDTH  read addresses
  i_reqN_wa  input  ADDR_WIDTH  write address
  i_reqN_wdata  input  DATA_WIDTH  write data
  o_reqN_ready  output  1  grant; handshake = valid && ready
  o_rspN_valid  output  1  read response strobe
  o_rspN_data0, o_rspN_data1  output  DATA_WIDTH  read response data
  o_reg0, o_reg1, o_reg2  output  ADDR_WIDTH  register-file read0/read1/write addresses
  o_data2  output  DATA_WIDTH  register-file write data
  i_data0, i_data1  input  DATA_WIDTH  register-file read data (combinational from o_reg0/o_reg1)

Function
REQ-005 At most one o_reqN_ready SHALL be 1 per cycle; ready SHALL be combinational from state and current valids, and SHALL be 0 for a requester whose valid is 0.
REQ-006 States SHALL be IDLE, OWN0, OWN1; plus last-grant pointer LG (1 bit) and hold counter HC (4 bits).
REQ-007 Normal arbitration (IDLE, or OWNx whose owner has valid=0 or expired): single valid -> grant it; both valid -> grant requester != LG.
REQ-008 In OWNx with i_reqx_valid=1 and HC<MAX_HOLD, requester x SHALL be granted regardless of the other requester.
REQ-009 On each handshake by x: LG<=x; if i_reqx_lock=1 -> state OWNx, HC<=HC+1 (HC<=1 if entering from other state or expiry); else state IDLE, HC<=0.
REQ-010 Expiry: OWNx with HC==MAX_HOLD SHALL arbitrate normally that cycle; if other requester valid, it wins; otherwise x may be re-granted with HC restarting at 1.
REQ-011 No handshake in a cycle -> state IDLE, HC<=0, LG unchanged.
REQ-012 During a handshake, o_reg0/o_reg1 SHALL equal granted ra0/ra1; o_reg2/o_data2 SHALL equal wa/wdata if we=1, else 0/0; with no handshake all o_reg*, o_data2 SHALL be 0.
REQ-013 Address 0 on o_reg2 SHALL be the only write-disable mechanism; writes to R0 pass through and are discarded by the register file.
REQ-014 Read latency SHALL be 1 cycle: o_rspN_valid=1 exactly one cycle after requester N handshake, o_rspN_data0/1 = i_data0/1 sampled at that handshake edge; otherwise o_rspN_valid=0, data held.
REQ-015 Read and write of the same register in one handshake SHALL return the pre-write value; write visible to the next handshake.
REQ-016 Back-to-back handshakes SHALL be sustained at 1 per cycle with no bubbles.

Reset
REQ-017 With i_RSTn=0 at a rising edge: state IDLE, HC=0, LG=1 (requester 0 wins first tie), o_rspN_valid=0, o_rspN_data0/1=0.
REQ-018 While i_RSTn=0, o_reqN_ready, o_reg0/1/2, o_data2 SHALL be 0; reset mid-ownership SHALL discard ownership and any pending response.

Verification
REQ-019 req0 write wa=1 wdata=0x55, next cycle req0 ra0=1 -> ready0=1 both cycles, rsp0 valid one cycle later with data0=0x55.
REQ-020 After reset both valid, lock=0, for 4 cycles -> grants 0,1,0,1; rsp strobes follow each by 1 cycle.
REQ-021 req0 valid+lock 6 cycles, req1 valid throughout -> req0 granted cycles 1-4, req1 cycle 5, req0 cycle 6.
REQ-022 req1 we=1 wa=5 wdata=0x77 ra0=5 (R5=0) -> rsp1 data0=0x00; next req1 ra0=5 -> data0=0x77.
REQ-023 req0 write wa=0 wdata=0xFF then ra0=0 -> data0=0x00; o_reg2=0 in cycle with we=0.
REQ-024 Assert i_RSTn=0 during OWN1 at HC=2 -> ready and rsp valid 0 next cycle; after release with both valid, requester 0 granted first.

Source files
------------

// File: rtl/regs_arbiter.sv
// regs_arbiter: two-requester register-file port arbiter with lock/hold ownership and 1-cycle read response
module regs_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_req0_valid,
  input  logic                  i_req0_lock,
  input  logic                  i_req0_we,
  input  logic [ADDR_WIDTH-1:0] i_req0_ra0,
  input  logic [ADDR_WIDTH-1:0] i_req0_ra1,
  input  logic [ADDR_WIDTH-1:0] i_req0_wa,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_req0_ready,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_data0,
  output logic [DATA_WIDTH-1:0] o_rsp0_data1,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_lock,
  input  logic                  i_req1_we,
  input  logic [ADDR_WIDTH-1:0] i_req1_ra0,
  input  logic [ADDR_WIDTH-1:0] i_req1_ra1,
  input  logic [ADDR_WIDTH-1:0] i_req1_wa,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_req1_ready,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_data0,
  output logic [DATA_WIDTH-1:0] o_rsp1_data1,
  output logic [ADDR_WIDTH-1:0] o_reg0,
  output logic [ADDR_WIDTH-1:0] o_reg1,
  output logic [ADDR_WIDTH-1:0] o_reg2,
  output logic [DATA_WIDTH-1:0] o_data2,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nx;
  logic lg, lg_nx, hold0, hold1, g0, g1, hs, lock, re_own, we;
  logic [3:0] hc, hc_nx;
  always_comb begin
    hold0 = state == OWN0 && i_req0_valid && hc < 4'(MAX_HOLD);
    hold1 = state == OWN1 && i_req1_valid && hc < 4'(MAX_HOLD);
    // unexpired owner wins outright; otherwise a tie goes to the requester that is not LG
    g0 = i_RSTn && i_req0_valid && (hold0 || (!hold1 && (!i_req1_valid || lg)));
    g1 = i_RSTn && i_req1_valid && (hold1 || (!hold0 && (!i_req0_valid || !lg)));
    hs = g0 || g1;
    lock = g1 ? i_req1_lock : i_req0_lock;
    re_own = g1 ? hold1 : hold0;
    we = hs && (g1 ? i_req1_we : i_req0_we);
    state_nx = hs && lock ? (g1 ? OWN1 : OWN0) : IDLE;
    hc_nx = hs && lock ? (re_own ? hc + 4'd1 : 4'd1) : 4'd0;
    lg_nx = hs ? g1 : lg;
    o_req0_ready = g0;
    o_req1_ready = g1;
    o_reg0 = hs ? (g1 ? i_req1_ra0 : i_req0_ra0) : '0;
    o_reg1 = hs ? (g1 ? i_req1_ra1 : i_req0_ra1) : '0;
    o_reg2 = we ? (g1 ? i_req1_wa : i_req0_wa) : '0;
    o_data2 = we ? (g1 ? i_req1_wdata : i_req0_wdata) : '0;
  end
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state <= IDLE;
      hc <= 4'd0;
      lg <= 1'b1;
      o_rsp0_valid <= 1'b0;
      o_rsp1_valid <= 1'b0;
      o_rsp0_data0 <= '0;
      o_rsp0_data1 <= '0;
      o_rsp1_data0 <= '0;
      o_rsp1_data1 <= '0;
    end else begin
      state <= state_nx;
      hc <= hc_nx;
      lg <= lg_nx;
      o_rsp0_valid <= g0;
      o_rsp1_valid <= g1;
      if (g0) begin
        o_rsp0_data0 <= i_data0;
        o_rsp0_data1 <= i_data1;
      end
      if (g1) begin
        o_rsp1_data0 <= i_data0;
        o_rsp1_data1 <= i_data1;
      end
    end
  end
endmodule

// File: tb/tb_regs_arbiter.sv
// tb_regs_arbiter: directed scenarios plus randomized traffic checked against a behavioural arbiter/register-file model
module tb_regs_arbiter;
  localparam int MAXH = 4;
  logic clk = 0, rst;
  logic v[2], lk[2], we[2];
  logic [4:0] ra0[2], ra1[2], wa[2];
  logic [7:0] wd[2];
  logic r0, r1, rv0, rv1;
  logic [7:0] d00, d01, d10, d11, o_data2, i_data0, i_data1;
  logic [4:0] o_reg0, o_reg1, o_reg2;
  logic [7:0] rf[32];
  int total = 0, bad = 0;
  int m_own = -1, m_hc = 0, m_lg = 1;
  logic m_rv[2];
  logic [7:0] m_d0[2], m_d1[2], mrf[32];

  always #5 clk = ~clk;

  regs_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .MAX_HOLD(MAXH)) dut (
    .i_CLK(clk), .i_RSTn(rst),
    .i_req0_valid(v[0]), .i_req0_lock(lk[0]), .i_req0_we(we[0]),
    .i_req0_ra0(ra0[0]), .i_req0_ra1(ra1[0]), .i_req0_wa(wa[0]), .i_req0_wdata(wd[0]),
    .o_req0_ready(r0), .o_rsp0_valid(rv0), .o_rsp0_data0(d00), .o_rsp0_data1(d01),
    .i_req1_valid(v[1]), .i_req1_lock(lk[1]), .i_req1_we(we[1]),
    .i_req1_ra0(ra0[1]), .i_req1_ra1(ra1[1]), .i_req1_wa(wa[1]), .i_req1_wdata(wd[1]),
    .o_req1_ready(r1), .o_rsp1_valid(rv1), .o_rsp1_data0(d10), .o_rsp1_data1(d11),
    .o_reg0(o_reg0), .o_reg1(o_reg1), .o_reg2(o_reg2), .o_data2(o_data2),
    .i_data0(i_data0), .i_data1(i_data1)
  );

  // register file environment: R0 is never written so it always reads 0
  assign i_data0 = rf[o_reg0];
  assign i_data1 = rf[o_reg1];
  always @(posedge clk) if (o_reg2 != 0) rf[o_reg2] <= o_data2;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      v[k] = 0; lk[k] = 0; we[k] = 0; ra0[k] = 0; ra1[k] = 0; wa[k] = 0; wd[k] = 0;
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1 clr();
  endtask

  task automatic rst_cyc();
    nx(); rst = 0;
    nx(); rst = 1;
  endtask

  always @(negedge clk) begin
    int g, gi;
    if (!rst) g = -1;
    else if (m_own >= 0 && v[m_own] && m_hc < MAXH) g = m_own;
    else if (v[0] && v[1]) g = 1 - m_lg;
    else if (v[0]) g = 0;
    else if (v[1]) g = 1;
    else g = -1;
    gi = g < 0 ? 0 : g;
    chk("m_ready0", r0, g == 0);
    chk("m_ready1", r1, g == 1);
    chk("m_reg0", o_reg0, g >= 0 ? ra0[gi] : 0);
    chk("m_reg1", o_reg1, g >= 0 ? ra1[gi] : 0);
    chk("m_reg2", o_reg2, g >= 0 && we[gi] ? wa[gi] : 0);
    chk("m_data2", o_data2, g >= 0 && we[gi] ? wd[gi] : 0);
    chk("m_rsp0_valid", rv0, m_rv[0]);
    chk("m_rsp1_valid", rv1, m_rv[1]);
    chk("m_rsp0_data", {d01, d00}, {m_d1[0], m_d0[0]});
    chk("m_rsp1_data", {d11, d10}, {m_d1[1], m_d0[1]});
    if (!rst) begin
      m_own = -1; m_hc = 0; m_lg = 1;
      for (int k = 0; k < 2; k++) begin m_rv[k] = 0; m_d0[k] = 0; m_d1[k] = 0; end
    end else begin
      for (int k = 0; k < 2; k++) m_rv[k] = (g == k);
      if (g >= 0) begin
        m_d0[g] = mrf[ra0[g]];
        m_d1[g] = mrf[ra1[g]];
        if (we[g] && wa[g] != 0) mrf[wa[g]] = wd[g];
        if (lk[g]) begin
          m_hc = (m_own == g && m_hc < MAXH) ? m_hc + 1 : 1;
          m_own = g;
        end else begin
          m_own = -1; m_hc = 0;
        end
        m_lg = g;
      end else begin
        m_own = -1; m_hc = 0;
      end
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) begin rf[k] = 0; mrf[k] = 0; end
    for (int k = 0; k < 2; k++) begin m_rv[k] = 0; m_d0[k] = 0; m_d1[k] = 0; end
    clr(); rst = 0;
    repeat (2) begin
      nx(); v[0] = 1; v[1] = 1;
      #3 chk("rst_ready", {r1, r0}, 0); chk("rst_rsp", {rv1, rv0}, 0); chk("rst_reg0", o_reg0, 0);
    end
    nx(); rst = 1; v[0] = 1; we[0] = 1; wa[0] = 1; wd[0] = 8'h55;
    #3 chk("w_ready0", r0, 1); chk("w_reg2", o_reg2, 1); chk("w_data2", o_data2, 8'h55);
    nx(); v[0] = 1; ra0[0] = 1;
    #3 chk("r_ready0", r0, 1); chk("r_reg0", o_reg0, 1); chk("r_reg2_nowe", o_reg2, 0);
    nx();
    #3 chk("r_rsp0_valid", rv0, 1); chk("r_rsp0_data0", d00, 8'h55);
    rst_cyc();
    for (int i = 0; i < 5; i++) begin
      nx(); if (i < 4) begin v[0] = 1; v[1] = 1; end
      #3 if (i < 4) chk("alt_ready0", r0, i % 2 == 0);
      if (i > 0) begin chk("alt_rsp0", rv0, (i - 1) % 2 == 0); chk("alt_rsp1", rv1, (i - 1) % 2 == 1); end
    end
    rst_cyc();
    for (int i = 0; i < 6; i++) begin
      nx(); v[0] = 1; lk[0] = 1; v[1] = 1;
      #3 chk("hold_ready0", r0, i != 4); chk("hold_ready1", r1, i == 4);
    end
    nx(); v[1] = 1; we[1] = 1; wa[1] = 5; wd[1] = 8'h77; ra0[1] = 5;
    #3 chk("rw_ready1", r1, 1);
    nx(); v[1] = 1; ra0[1] = 5;
    #3 chk("rw_old", d10, 0);
    nx();
    #3 chk("rw_new", d10, 8'h77);
    nx(); v[0] = 1; we[0] = 1; wa[0] = 0; wd[0] = 8'hff;
    #3 chk("r0w_reg2", o_reg2, 0); chk("r0w_data2", o_data2, 8'hff);
    nx(); v[0] = 1;
    nx();
    #3 chk("r0_data0", d00, 0);
    rst_cyc();
    repeat (2) begin nx(); v[1] = 1; lk[1] = 1; end
    nx(); rst = 0; v[0] = 1; v[1] = 1; lk[1] = 1;
    #3 chk("midrst_ready", {r1, r0}, 0);
    nx(); v[0] = 1; v[1] = 1;
    #3 chk("midrst_rsp1", rv1, 0); chk("midrst_ready2", {r1, r0}, 0);
    nx(); rst = 1; v[0] = 1; v[1] = 1;
    #3 chk("post_rst_ready0", r0, 1);
    repeat (3000) begin
      nx();
      rst = ($urandom_range(0, 40) != 0);
      for (int k = 0; k < 2; k++) begin
        v[k] = ($urandom_range(0, 3) != 0);
        lk[k] = ($urandom_range(0, 2) != 0);
        we[k] = ($urandom_range(0, 1) != 0);
        ra0[k] = 5'($urandom_range(0, 7));
        ra1[k] = 5'($urandom_range(0, 7));
        wa[k] = 5'($urandom_range(0, 7));
        wd[k] = 8'($urandom);
      end
    end
    nx();
    #10;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
